regfile_arbiter: RTL and testbench

REGFILE_ARBITER -- requirements
Module: regfile_arbiter

---
 rtl/regfile_pkg.sv | 18 +
 rtl/regfile_core.sv | 41 ++++
 rtl/regfile_arbiter.sv | 105 ++++++++++
 tb/tb_regfile_arbiter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and requester index type for the two-port register file arbiter
package regfile_pkg;

  localparam int B_DEF = 8;
  localparam int W_DEF = 2;

  typedef enum logic {
    REQ_0 = 1'b0,
    REQ_1 = 1'b1
  } req_idx_e;

  // Requester 1 wins a contention only in round-robin mode, and only when
  // requester 0 was the most recent winner.
  function automatic logic req1_wins_conflict(input req_idx_e last_gnt, input logic rr_en);
    return rr_en && (last_gnt == REQ_0);
  endfunction

endpackage

// File: rtl/regfile_core.sv
// rtl/regfile_core.sv - synchronous 2**W x B storage array with registered read port
module regfile_core
  import regfile_pkg::*;
#(
  parameter int B = B_DEF,
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [W-1:0] w_addr,
  input  logic [B-1:0] w_data,
  input  logic         rd_en,
  input  logic [W-1:0] r_addr,
  output logic [B-1:0] r_data
);

  localparam int DEPTH = 2 ** W;

  logic [B-1:0] mem_q [DEPTH];
  logic [B-1:0] r_data_q;

  // Storage array: written on wr_en, never reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[w_addr] <= w_data;
    end
  end

  // Read register: loads only on a read cycle so it holds between reads.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data_q <= '0;
    end else if (rd_en && !wr_en) begin
      r_data_q <= mem_q[r_addr];
    end
  end

  assign r_data = r_data_q;

endmodule

// File: rtl/regfile_arbiter.sv
// rtl/regfile_arbiter.sv - two-requester single-port register file arbiter; REGFILE_ARB_RR_EN selects round-robin
module regfile_arbiter
  import regfile_pkg::*;
#(
  parameter int B = B_DEF,
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0,
  input  logic         we0,
  input  logic [W-1:0] addr0,
  input  logic [B-1:0] wdata0,
  output logic         ack0,
  output logic         rvalid0,
  input  logic         req1,
  input  logic         we1,
  input  logic [W-1:0] addr1,
  input  logic [B-1:0] wdata1,
  output logic         ack1,
  output logic         rvalid1,
  output logic [B-1:0] rdata
);

`ifdef REGFILE_ARB_RR_EN
  localparam logic RR_EN = 1'b1;
`else
  localparam logic RR_EN = 1'b0;
`endif

  req_idx_e     last_gnt_q, last_gnt_d;
  logic         rvalid0_q, rvalid0_d;
  logic         rvalid1_q, rvalid1_d;
  logic         win1;
  logic         gnt0, gnt1;
  logic         sel_we;
  logic [W-1:0] sel_addr;
  logic [B-1:0] sel_wdata;
  logic         core_wr_en, core_rd_en;

  // Grant decode: a lone requester wins immediately; contention uses the mode policy.
  always_comb begin
    win1 = req1_wins_conflict(last_gnt_q, RR_EN);
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      gnt0 = req0 && (!req1 || !win1);
      gnt1 = req1 && (!req0 ||  win1);
    end
  end

  // Steer the winner's command to the single storage port.
  always_comb begin
    sel_we     = gnt1 ? we1    : we0;
    sel_addr   = gnt1 ? addr1  : addr0;
    sel_wdata  = gnt1 ? wdata1 : wdata0;
    core_wr_en = (gnt0 || gnt1) && sel_we;
    core_rd_en = (gnt0 || gnt1) && !sel_we;
  end

  // Next-state for the pointer and the one-cycle read-valid flags.
  always_comb begin
    last_gnt_d = last_gnt_q;
    if (gnt0) begin
      last_gnt_d = REQ_0;
    end else if (gnt1) begin
      last_gnt_d = REQ_1;
    end
    rvalid0_d = gnt0 && !we0;
    rvalid1_d = gnt1 && !we1;
  end

  // Control registers; last_gnt starts at 1 so requester 0 wins the first contention.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_gnt_q <= REQ_1;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
    end else begin
      last_gnt_q <= last_gnt_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
    end
  end

  regfile_core #(
    .B(B),
    .W(W)
  ) u_core (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (core_wr_en),
    .w_addr (sel_addr),
    .w_data (sel_wdata),
    .rd_en  (core_rd_en),
    .r_addr (sel_addr),
    .r_data (rdata)
  );

  assign ack0    = gnt0;
  assign ack1    = gnt1;
  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// tb/tb_regfile_arbiter.sv - table-driven scoreboard bench for regfile_arbiter
module tb_regfile_arbiter;

`ifdef REGFILE_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       req0, we0, req1, we1;
  logic [1:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       ack0, ack1, rvalid0, rvalid1;
  logic [7:0] rdata;

  always #5 clk = ~clk;

  regfile_arbiter #(.B(8), .W(2)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rvalid0(rvalid0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rvalid1(rvalid1),
    .rdata(rdata)
  );

  typedef struct {
    logic r0, w0; logic [1:0] a0; logic [7:0] d0;
    logic r1, w1; logic [1:0] a1; logic [7:0] d1;
    logic k0, k1;
  } vec_t;

  typedef struct {
    logic rv0, rv1; logic [7:0] data;
  } exp_t;

  vec_t       vecs[$];
  exp_t       sb[$];
  logic [7:0] model_mem [4];
  logic [7:0] model_rdata;
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic r0, w0, input logic [1:0] a0, input logic [7:0] d0,
                              input logic r1, w1, input logic [1:0] a1, input logic [7:0] d1,
                              input logic k0, k1);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.k0 = k0; v.k1 = k1;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    req0 = v.r0; we0 = v.w0; addr0 = v.a0; wdata0 = v.d0;
    req1 = v.r1; we1 = v.w1; addr1 = v.a1; wdata1 = v.d1;
  endtask

  task automatic check_outputs(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_rvalid0"}, {31'd0, rvalid0}, {31'd0, e.rv0});
      chk({tag, "_rvalid1"}, {31'd0, rvalid1}, {31'd0, e.rv1});
      chk({tag, "_rdata"}, {24'd0, rdata}, {24'd0, e.data});
    end
  endtask

  // Expected read result one cycle later, from the bench's own memory model.
  task automatic push_expect(input vec_t v);
    exp_t e;
    e.rv0 = v.k0 && !v.w0;
    e.rv1 = v.k1 && !v.w1;
    if (e.rv0) model_rdata = model_mem[v.a0];
    else if (e.rv1) model_rdata = model_mem[v.a1];
    e.data = model_rdata;
    if (v.k0 && v.w0) model_mem[v.a0] = v.d0;
    if (v.k1 && v.w1) model_mem[v.a1] = v.d1;
    sb.push_back(e);
  endtask

  initial begin
    vec_t idle;
    vec_t v;
    idle = mk(0, 0, 2'd0, 8'd0, 0, 0, 2'd0, 8'd0, 0, 0);

    // Writes by requester 0, then back-to-back reads by requester 1.
    for (int i = 0; i < 4; i++) vecs.push_back(mk(1, 1, 2'(i), 8'(100 + 10 * i), 0, 0, 2'd0, 8'd0, 1, 0));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 0, 2'd0, 8'd0, 1, 0, 2'(i), 8'd0, 0, 1));
    vecs.push_back(idle);
    vecs.push_back(idle);
    // Both read continuously: alternate under round-robin, requester 0 always otherwise.
    for (int i = 0; i < 4; i++) begin
      logic k0;
      k0 = RR ? (i % 2 == 0) : 1'b1;
      vecs.push_back(mk(1, 0, 2'd0, 8'd0, 1, 0, 2'd1, 8'd0, k0, !k0));
    end
    // Write 140 to addr 3, read it back next cycle from the other side.
    vecs.push_back(mk(1, 1, 2'd3, 8'd140, 0, 0, 2'd0, 8'd0, 1, 0));
    vecs.push_back(mk(0, 0, 2'd0, 8'd0, 1, 0, 2'd3, 8'd0, 0, 1));
    vecs.push_back(idle);
    vecs.push_back(idle);

    // Reset state, with requests asserted to show they are masked.
    reset = 1'b1;
    drive(mk(1, 0, 2'd0, 8'd0, 1, 0, 2'd0, 8'd0, 0, 0));
    #2;
    chk("rst_ack0", {31'd0, ack0}, 32'd0);
    chk("rst_ack1", {31'd0, ack1}, 32'd0);
    chk("rst_rvalid0", {31'd0, rvalid0}, 32'd0);
    chk("rst_rvalid1", {31'd0, rvalid1}, 32'd0);
    chk("rst_rdata", {24'd0, rdata}, 32'd0);
    @(negedge clk);
    drive(idle);
    reset = 1'b0;
    model_rdata = 8'd0;
    for (int i = 0; i < 4; i++) model_mem[i] = 8'hxx;
    sb.push_back('{rv0: 1'b0, rv1: 1'b0, data: 8'd0});

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      check_outputs($sformatf("v%0d", i));
      v = vecs[i];
      drive(v);
      #1;
      chk($sformatf("v%0d_ack0", i), {31'd0, ack0}, {31'd0, v.k0});
      chk($sformatf("v%0d_ack1", i), {31'd0, ack1}, {31'd0, v.k1});
      push_expect(v);
    end
    @(negedge clk);
    check_outputs("tail");

    // Reset in the cycle after a granted read cancels the pending rvalid.
    drive(mk(1, 0, 2'd3, 8'd0, 0, 0, 2'd0, 8'd0, 1, 0));
    #1;
    chk("rstrd_ack0", {31'd0, ack0}, 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive(idle);
    #1;
    chk("rstrd_rvalid0", {31'd0, rvalid0}, 32'd0);
    chk("rstrd_rdata", {24'd0, rdata}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_rvalid0", {31'd0, rvalid0}, 32'd0);
    chk("post_rst_rdata", {24'd0, rdata}, 32'd0);
    drive(mk(0, 0, 2'd0, 8'd0, 1, 0, 2'd3, 8'd0, 0, 1));
    #1;
    chk("post_rst_ack1", {31'd0, ack1}, 32'd1);
    @(negedge clk);
    drive(idle);
    chk("post_rst_rvalid1", {31'd0, rvalid1}, 32'd1);
    chk("post_rst_rdata140", {24'd0, rdata}, 32'd140);
    @(negedge clk);
    chk("post_rst_rvalid1_pulse", {31'd0, rvalid1}, 32'd0);
    chk("post_rst_rdata_hold", {24'd0, rdata}, 32'd140);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
